// File: rtl/oops_structs.sv
// Shared core types for the out-of-order pipeline.
//   CPU_RS_DEPTH / NUM_CDB_INPUTS / ROB_IDX_LEN / XLEN : sizing constants
//   reservation_station_element_t : one waiting instruction. CBn=1 means
//                                    operand n is pending and valn[tag bits]
//                                    holds the producing ROB tag.
//   cdb_lane_t / common_data_bus_t : result broadcast lanes plus flush (fls)
package oops_structs;

    localparam int CPU_RS_DEPTH   = 6;
    localparam int NUM_CDB_INPUTS = 6;
    localparam int ROB_IDX_LEN    = 4;
    localparam int XLEN           = 32;

    typedef struct packed {
        logic                   valid;
        logic [3:0]             op;
        logic [ROB_IDX_LEN-1:0] rob_idx;
        logic                   CB1;
        logic [XLEN-1:0]        val1;
        logic                   CB2;
        logic [XLEN-1:0]        val2;
    } reservation_station_element_t;

    typedef struct packed {
        logic                   valid;
        logic [ROB_IDX_LEN-1:0] ROB_dest;
        logic [XLEN-1:0]        data;
    } cdb_lane_t;

    typedef struct packed {
        cdb_lane_t [NUM_CDB_INPUTS-1:0] lanes;
        logic                           fls;
    } common_data_bus_t;

endpackage

// File: rtl/cdb_operand_snoop.sv
// Tag match and lane priority for one operand.
//   cb, val   : current operand state (pending flag and tag/value)
//   cdb       : broadcast bus
//   cb_next   : pending flag after this cycle's broadcasts
//   val_next  : value after this cycle's broadcasts
// When several lanes carry the matching tag, the lowest lane index wins.
module cdb_operand_snoop
    import oops_structs::*;
#(
    parameter int NUM_LANES = NUM_CDB_INPUTS,
    parameter int TAG_W     = ROB_IDX_LEN
) (
    input  logic             cb,
    input  logic [XLEN-1:0]  val,
    input  common_data_bus_t cdb,
    output logic             cb_next,
    output logic [XLEN-1:0]  val_next
);

    logic hit;

    always_comb begin
        hit      = 1'b0;
        cb_next  = cb;
        val_next = val;
        if (cb) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (!hit && cdb.lanes[l].valid &&
                    cdb.lanes[l].ROB_dest[TAG_W-1:0] == val[TAG_W-1:0]) begin
                    hit      = 1'b1;
                    cb_next  = 1'b0;
                    val_next = cdb.lanes[l].data;
                end
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Age-ordered, compacting reservation station.
//   clk, rst_n   : clock, asynchronous active-low reset
//   alloc_valid  : dispatch offers alloc_entry
//   alloc_entry  : entry to store (operands may still be pending)
//   alloc_ready  : entry accepted this cycle when high with alloc_valid
//   cdb          : result broadcast lanes and flush
//   issue_valid  : issue_entry is the oldest entry with both operands ready
//   issue_entry  : that entry, all-zero when issue_valid=0
//   issue_ready  : execute unit takes issue_entry this cycle
//   count        : number of occupied slots
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid/entry are held until taken unless a flush intervenes or
// an older entry becomes ready.
// Slot 0 is the oldest entry; occupied slots are always contiguous from 0.
module reservation_station
    import oops_structs::*;
#(
    parameter int DEPTH     = CPU_RS_DEPTH,
    parameter int NUM_LANES = NUM_CDB_INPUTS,
    parameter int TAG_W     = ROB_IDX_LEN,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         alloc_valid,
    input  reservation_station_element_t alloc_entry,
    output logic                         alloc_ready,
    input  common_data_bus_t             cdb,
    output logic                         issue_valid,
    output reservation_station_element_t issue_entry,
    input  logic                         issue_ready,
    output logic [CNT_W-1:0]             count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    reservation_station_element_t q       [DEPTH];
    reservation_station_element_t shifted [DEPTH];
    reservation_station_element_t nxt     [DEPTH];
    // Snoop sources: slots 0..DEPTH-1 are the post-shift entries, slot DEPTH
    // is the incoming allocation so a coincident broadcast is not lost.
    reservation_station_element_t src     [DEPTH+1];
    reservation_station_element_t alloc_woken;

    logic [DEPTH:0]   woke_cb1;
    logic [DEPTH:0]   woke_cb2;
    logic [XLEN-1:0]  woke_val1 [DEPTH+1];
    logic [XLEN-1:0]  woke_val2 [DEPTH+1];

    logic             found;
    logic [IDX_W-1:0] sel;
    logic             do_issue;
    logic             do_alloc;
    logic [IDX_W-1:0] alloc_pos;
    logic [CNT_W-1:0] count_nxt;

    // Oldest ready entry, from registered state only.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!found && q[i].valid && !q[i].CB1 && !q[i].CB2) begin
                found = 1'b1;
                sel   = IDX_W'(i);
            end
        end
    end

    assign issue_valid = found && !cdb.fls;
    assign issue_entry = issue_valid ? q[sel] : '0;
    assign alloc_ready = rst_n && (count < CNT_W'(DEPTH)) && !cdb.fls;
    assign do_issue    = issue_valid && issue_ready;
    assign do_alloc    = alloc_valid && alloc_ready;
    // Allocation lands in the first free slot after any same-cycle removal.
    assign alloc_pos   = IDX_W'(count - CNT_W'(do_issue));
    assign count_nxt   = count + CNT_W'(do_alloc) - CNT_W'(do_issue);

    // Remove the issued slot and close the gap.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) shifted[i] = q[i];
        if (do_issue) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (i >= int'(sel)) shifted[i] = q[i+1];
            end
            shifted[DEPTH-1] = '0;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) src[i] = shifted[i];
        src[DEPTH] = alloc_entry;
    end

    for (genvar i = 0; i <= DEPTH; i++) begin : g_snoop
        cdb_operand_snoop #(.NUM_LANES(NUM_LANES), .TAG_W(TAG_W)) u_op1 (
            .cb       (src[i].CB1),
            .val      (src[i].val1),
            .cdb      (cdb),
            .cb_next  (woke_cb1[i]),
            .val_next (woke_val1[i])
        );
        cdb_operand_snoop #(.NUM_LANES(NUM_LANES), .TAG_W(TAG_W)) u_op2 (
            .cb       (src[i].CB2),
            .val      (src[i].val2),
            .cdb      (cdb),
            .cb_next  (woke_cb2[i]),
            .val_next (woke_val2[i])
        );
    end

    // Empty slots are kept all-zero so stale data never reaches issue_entry.
    always_comb begin
        alloc_woken       = alloc_entry;
        alloc_woken.valid = 1'b1;
        alloc_woken.CB1   = woke_cb1[DEPTH];
        alloc_woken.val1  = woke_val1[DEPTH];
        alloc_woken.CB2   = woke_cb2[DEPTH];
        alloc_woken.val2  = woke_val2[DEPTH];
        for (int i = 0; i < DEPTH; i++) begin
            nxt[i] = '0;
            if (shifted[i].valid) begin
                nxt[i]      = shifted[i];
                nxt[i].CB1  = woke_cb1[i];
                nxt[i].val1 = woke_val1[i];
                nxt[i].CB2  = woke_cb2[i];
                nxt[i].val2 = woke_val2[i];
            end
        end
        if (do_alloc) nxt[alloc_pos] = alloc_woken;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            count <= '0;
        end else if (cdb.fls) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) q[i] <= nxt[i];
            count <= count_nxt;
        end
    end

endmodule
